alu_data_mem_port: RTL and testbench

- Data-memory responder that consumes the ALU's 10-bit byte address (ALU result truncated) plus load/store requests from the CPU datapath.
- Returns load data and store acknowledgements over a valid/ready handshake.
- Holds a little-endian 1 KB word array with byte-enable writes.
- Supports byte, half-word and word access with sign/zero extension and alignment checking.

---
 rtl/alu_data_mem_port_if.sv | 29 ++
 rtl/alu_data_mem_port.sv | 139 +++++++++++++
 tb/tb_alu_data_mem_port.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/alu_data_mem_port_if.sv
// rtl/alu_data_mem_port_if.sv - request/response bundle between CPU datapath and data-memory port
interface alu_data_mem_port_if #(
  parameter int ADDR_W = 10
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              resp_is_write;

  // Requester side (CPU datapath)
  modport master (
    output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, resp_is_write
  );

  // Responder side (memory port)
  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, resp_is_write
  );
endinterface

// File: rtl/alu_data_mem_port.sv
// rtl/alu_data_mem_port.sv - little-endian byte-addressed data memory with load/store handshake
module alu_data_mem_port #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_data_mem_port_if.slave   bus
);
  localparam int DEPTH = 2 ** (ADDR_W - 2);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [DATA_W-1:0] wdata_q;

  logic              accept;
  logic              req_err;
  logic [DATA_W-1:0] rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [DATA_W-1:0] load_data;
  logic [3:0]        wr_mask;
  logic [DATA_W-1:0] wr_data;

  // Only one request in flight; ready is forced low while reset is held
  assign bus.req_ready = (state == IDLE) && !reset;
  assign accept        = bus.req_valid && bus.req_ready;

  // Misalignment / illegal-size detection on the incoming request
  always_comb begin
    req_err = 1'b0;
    case (bus.req_size)
      2'b01:   req_err = bus.req_addr[0];
      2'b10:   req_err = |bus.req_addr[1:0];
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
  end

  // Lane select and sign/zero extension of the addressed word
  always_comb begin
    rd_word   = mem[addr_q[ADDR_W-1:2]];
    rd_byte   = rd_word[8*addr_q[1:0] +: 8];
    rd_half   = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = rd_word;
    case (size_q)
      2'b00:   load_data = {{24{~uns_q & rd_byte[7]}}, rd_byte};
      2'b01:   load_data = {{16{~uns_q & rd_half[15]}}, rd_half};
      default: load_data = rd_word;
    endcase
  end

  // Store data replicated across lanes; the mask picks which lanes commit
  always_comb begin
    wr_mask = 4'hF;
    wr_data = wdata_q;
    case (size_q)
      2'b00: begin
        wr_mask = 4'b0001 << addr_q[1:0];
        wr_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wr_mask = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata_q[15:0]}};
      end
      default: begin
        wr_mask = 4'hF;
        wr_data = wdata_q;
      end
    endcase
  end

  // Byte-enable array write; a reset landing on the WR cycle cancels it
  always_ff @(posedge clk) begin
    if (state == WR && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i]) mem[addr_q[ADDR_W-1:2]][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Request/response sequencing with registered response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      bus.resp_valid    <= 1'b0;
      bus.resp_rdata    <= '0;
      bus.resp_err      <= 1'b0;
      bus.resp_is_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q            <= bus.req_addr;
            size_q            <= bus.req_size;
            uns_q             <= bus.req_unsigned;
            wdata_q           <= bus.req_wdata;
            bus.resp_is_write <= bus.req_write;
            if (req_err) begin
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
              bus.resp_valid <= 1'b1;
              state          <= RESP;
            end else if (bus.req_write) begin
              state <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          bus.resp_rdata <= load_data;
          bus.resp_err   <= 1'b0;
          bus.resp_valid <= 1'b1;
          state          <= RESP;
        end
        WR: begin
          bus.resp_rdata <= '0;
          bus.resp_err   <= 1'b0;
          bus.resp_valid <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_data_mem_port.sv
// tb/tb_alu_data_mem_port.sv - scoreboard bench for alu_data_mem_port
module tb_alu_data_mem_port;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  alu_data_mem_port_if #(.ADDR_W(10)) bus ();

  alu_data_mem_port #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        wr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one request, push its expected response, and measure response latency
  task automatic send(input string tag, input logic wr, input logic [9:0] addr,
                      input logic [1:0] size, input logic uns, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    int   n;
    int   lat;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.wr    = wr;
    sb.push_back(e);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wd;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) check({tag, " accept"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom());
    bus.req_addr  = 10'($urandom());
    bus.req_size  = 2'($urandom());
    bus.req_wdata = $urandom();
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, exp_err ? 32'd1 : 32'd2);
  endtask

  // Pop the expected response, compare, optionally stall, then complete the handshake
  task automatic collect(input string tag, input int hold);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, " scoreboard"}, sb.size(), 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, " rdata"}, bus.resp_rdata, e.rdata);
    check({tag, " err"}, 32'(bus.resp_err), 32'(e.err));
    check({tag, " is_write"}, 32'(bus.resp_is_write), 32'(e.wr));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold valid"}, 32'(bus.resp_valid), 32'd1);
      check({tag, " hold rdata"}, bus.resp_rdata, e.rdata);
      check({tag, " hold ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check({tag, " valid drop"}, 32'(bus.resp_valid), 32'd0);
    check({tag, " ready back"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic xact(input string tag, input logic wr, input logic [9:0] addr,
                      input logic [1:0] size, input logic uns, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input int hold);
    send(tag, wr, addr, size, uns, wd, exp_rd, exp_err);
    collect(tag, hold);
  endtask

  initial begin
    int n;
    reset            = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_addr     = '0;
    bus.req_size     = '0;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = '0;
    bus.resp_ready   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst req_ready", 32'(bus.req_ready), 32'd0);
    check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst rdata", bus.resp_rdata, 32'd0);
    check("rst err", 32'(bus.resp_err), 32'd0);
    check("rst is_write", 32'(bus.resp_is_write), 32'd0);
    reset = 1'b0;

    // Word store then load
    xact("st_w4", 1'b1, 10'h004, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    xact("ld_w4", 1'b0, 10'h004, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 0);

    // Byte merge into an existing word, then all load widths/extensions
    xact("st_w8", 1'b1, 10'h008, 2'b10, 1'b0, 32'h11223344, 32'h0, 1'b0, 0);
    xact("st_b9", 1'b1, 10'h009, 2'b00, 1'b0, 32'hFFFFFF80, 32'h0, 1'b0, 0);
    xact("ld_b9s", 1'b0, 10'h009, 2'b00, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0, 0);
    xact("ld_b9u", 1'b0, 10'h009, 2'b00, 1'b1, 32'h0, 32'h00000080, 1'b0, 0);
    xact("ld_w8", 1'b0, 10'h008, 2'b10, 1'b1, 32'h0, 32'h11228044, 1'b0, 0);
    xact("ld_h8s", 1'b0, 10'h008, 2'b01, 1'b0, 32'h0, 32'hFFFF8044, 1'b0, 0);
    xact("ld_hAs", 1'b0, 10'h00A, 2'b01, 1'b0, 32'h0, 32'h00001122, 1'b0, 0);
    xact("ld_bBs", 1'b0, 10'h00B, 2'b00, 1'b0, 32'h0, 32'h00000011, 1'b0, 0);

    // Error cases, then confirm the array was not touched
    xact("err_h3", 1'b0, 10'h003, 2'b01, 1'b0, 32'h0, 32'h0, 1'b1, 0);
    xact("err_w2", 1'b0, 10'h002, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 0);
    xact("err_sz", 1'b0, 10'h000, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 0);
    xact("err_st6", 1'b1, 10'h006, 2'b10, 1'b0, 32'h55555555, 32'h0, 1'b1, 0);
    xact("err_stb", 1'b1, 10'h004, 2'b11, 1'b0, 32'h55555555, 32'h0, 1'b1, 0);
    xact("ld_w4b", 1'b0, 10'h004, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 0);

    // Backpressure on a load response
    xact("bp_ld", 1'b0, 10'h004, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 5);

    // Reset lands on the WR cycle of a store: no write, no response
    xact("st_3fc", 1'b1, 10'h3FC, 2'b10, 1'b0, 32'h12345678, 32'h0, 1'b0, 0);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b1;
    bus.req_addr     = 10'h3FC;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = 32'hCAFEF00D;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) check("abort accept", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("abort resp_valid", 32'(bus.resp_valid), 32'd0);
    check("abort req_ready", 32'(bus.req_ready), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort no resp", 32'(bus.resp_valid), 32'd0);
    end
    check("abort idle", 32'(bus.req_ready), 32'd1);
    xact("ld_3fc", 1'b0, 10'h3FC, 2'b10, 1'b0, 32'h0, 32'h12345678, 1'b0, 0);

    // Top-of-array half store and loads
    xact("st_h3fe", 1'b1, 10'h3FE, 2'b01, 1'b0, 32'hFFFFABCD, 32'h0, 1'b0, 0);
    xact("ld_h3feu", 1'b0, 10'h3FE, 2'b01, 1'b1, 32'h0, 32'h0000ABCD, 1'b0, 0);
    xact("ld_h3fes", 1'b0, 10'h3FE, 2'b01, 1'b0, 32'h0, 32'hFFFFABCD, 1'b0, 0);
    xact("ld_w3fc", 1'b0, 10'h3FC, 2'b10, 1'b0, 32'h0, 32'hABCD5678, 1'b0, 2);

    check("scoreboard drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
